// File: rtl/axi4_mem_read_master.sv
// axi4_mem_read_master: AXI4 INCR burst read initiator.
// Splits a beat-count command into 4 KB-safe bursts.
//
// Ports:
//   clk, reset      sole clock, synchronous active-high reset
//   s_cmd_*         command in: byte address, beat count
//   busy            high from command accept to completion
//   err             sticky RRESP error, cleared on accept
//   m_axi4_ar*      AXI4 read address channel (master side)
//   m_axi4_r*       AXI4 read data channel (master side)
//   m_data/m_last   read data stream, m_valid/m_ready handshake
module axi4_mem_read_master #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 49,
    parameter int AXI_DATA_SIZE  = 4,
    parameter int AXI_ARID       = 0,
    parameter int MAX_BURST_LEN  = 16,
    parameter int ISSUE_LIMIT    = 4,
    parameter int LEN_WIDTH      = 32,
    localparam int AXI_DATA_WIDTH = 8 << AXI_DATA_SIZE
) (
    input  logic                      reset,
    input  logic                      clk,
    input  logic [AXI_ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [LEN_WIDTH-1:0]      s_cmd_len,
    input  logic                      s_cmd_valid,
    output logic                      s_cmd_ready,
    output logic                      busy,
    output logic                      err,
    output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
    output logic [7:0]                m_axi4_arlen,
    output logic [2:0]                m_axi4_arsize,
    output logic [1:0]                m_axi4_arburst,
    output logic                      m_axi4_arlock,
    output logic [3:0]                m_axi4_arcache,
    output logic [2:0]                m_axi4_arprot,
    output logic [3:0]                m_axi4_arqos,
    output logic                      m_axi4_arvalid,
    input  logic                      m_axi4_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic [1:0]                m_axi4_rresp,
    input  logic                      m_axi4_rlast,
    input  logic                      m_axi4_rvalid,
    output logic                      m_axi4_rready,
    output logic [AXI_DATA_WIDTH-1:0] m_data,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK =
        AXI_ADDR_WIDTH'((1 << AXI_DATA_SIZE) - 1);
    localparam logic [LEN_WIDTH-1:0] MAX_N =
        LEN_WIDTH'(MAX_BURST_LEN);
    localparam logic [3:0] LIMIT = 4'(ISSUE_LIMIT);
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    state_t state_q, state_d;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]      rem_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      rcv_q, rcv_d;
    logic [3:0]                outst_q, outst_d;
    logic                      arvalid_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]                arlen_q;
    logic                      err_q;

    logic cmd_acc, ar_hs, r_hs, r_end, ar_free, ar_load;

    // Burst source: the command itself on accept,
    // otherwise the not-yet-issued remainder.
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr, src_addr;
    logic [LEN_WIDTH-1:0]      src_rem;
    logic [12:0]               bnd;
    logic [LEN_WIDTH-1:0]      bnd_n, cap_n, n, n_m1;
    logic [AXI_ADDR_WIDTH-1:0] step;

    assign s_cmd_ready = (state_q == IDLE) & ~reset;
    assign busy        = (state_q != IDLE);
    assign err         = err_q;

    assign cmd_acc = s_cmd_valid & s_cmd_ready;
    assign ar_hs   = arvalid_q & m_axi4_arready;
    assign r_hs    = m_axi4_rvalid & m_ready;
    assign r_end   = r_hs & m_axi4_rlast;
    assign ar_free = ~arvalid_q | ar_hs;

    assign cmd_addr = s_cmd_addr & ~LOW_MASK;

    assign bnd   = 13'd4096 - {1'b0, src_addr[11:0]};
    assign bnd_n = LEN_WIDTH'(bnd >> AXI_DATA_SIZE);
    assign cap_n = (bnd_n < MAX_N) ? bnd_n : MAX_N;
    assign n     = (src_rem < cap_n) ? src_rem : cap_n;
    assign n_m1  = n - ONE;
    assign step  = AXI_ADDR_WIDTH'(n) << AXI_DATA_SIZE;

    always_comb begin
        outst_d = outst_q;
        unique case ({ar_hs, r_end})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase
    end

    assign rcv_d = r_hs ? rcv_q + ONE : rcv_q;

    always_comb begin
        state_d  = state_q;
        ar_load  = 1'b0;
        src_addr = addr_q;
        src_rem  = rem_q;
        unique case (state_q)
            IDLE: begin
                src_addr = cmd_addr;
                src_rem  = s_cmd_len;
                if (cmd_acc) begin
                    if (s_cmd_len == '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                        ar_load = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (ar_free) begin
                    if (rem_q == '0) begin
                        state_d = DRAIN;
                    end else if (outst_d < LIMIT) begin
                        ar_load = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Look ahead so busy drops right after
                // the final beat handshake.
                if (rcv_d == len_q && outst_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            len_q     <= '0;
            rcv_q     <= '0;
            outst_q   <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            if (cmd_acc) begin
                len_q <= s_cmd_len;
                rcv_q <= '0;
                err_q <= 1'b0;
            end else begin
                rcv_q <= rcv_d;
                if (r_hs && m_axi4_rresp != 2'b00) begin
                    err_q <= 1'b1;
                end
            end
            if (ar_load) begin
                arvalid_q <= 1'b1;
                araddr_q  <= src_addr;
                arlen_q   <= n_m1[7:0];
                addr_q    <= src_addr + step;
                rem_q     <= src_rem - n;
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end
        end
    end

    assign m_axi4_arid    = AXI_ID_WIDTH'(AXI_ARID);
    assign m_axi4_araddr  = araddr_q;
    assign m_axi4_arlen   = arlen_q;
    assign m_axi4_arsize  = 3'(AXI_DATA_SIZE);
    assign m_axi4_arburst = 2'b01;
    assign m_axi4_arlock  = 1'b0;
    assign m_axi4_arcache = 4'b0011;
    assign m_axi4_arprot  = 3'b000;
    assign m_axi4_arqos   = 4'b0000;
    assign m_axi4_arvalid = arvalid_q;

    // Last flag comes from our own beat count, not
    // rlast, which marks burst ends only.
    assign m_axi4_rready = m_ready;
    assign m_valid       = m_axi4_rvalid;
    assign m_data        = m_axi4_rdata;
    assign m_last        = m_axi4_rvalid
                         & (rcv_q == len_q - ONE);

    logic unused_bits;
    assign unused_bits = ^{m_axi4_rid, n_m1[LEN_WIDTH-1:8]};

endmodule

// File: tb/tb_axi4_mem_read_master.sv
// tb_axi4_mem_read_master: self-checking bench.
// Memory slave model plus beat and AR scoreboards.
module tb_axi4_mem_read_master;

    typedef struct packed {
        logic [127:0] d;
        logic         l;
    } beat_t;

    typedef struct packed {
        logic [48:0] a;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [48:0] a;
        int          left;
    } burst_t;

    typedef struct {
        logic [48:0] addr;
        int          len;
        int          eb;
        bit          rnd;
        int          n_ar;
        bit          e_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [48:0]  s_cmd_addr;
    logic [31:0]  s_cmd_len;
    logic         s_cmd_valid;
    logic         s_cmd_ready;
    logic         busy, err;
    logic [5:0]   arid;
    logic [48:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic [3:0]   arqos;
    logic         arvalid, arready;
    logic [5:0]   rid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic [127:0] m_data;
    logic         m_last, m_valid, m_ready;

    always #5 clk = ~clk;

    axi4_mem_read_master dut (
        .reset          (reset),
        .clk            (clk),
        .s_cmd_addr     (s_cmd_addr),
        .s_cmd_len      (s_cmd_len),
        .s_cmd_valid    (s_cmd_valid),
        .s_cmd_ready    (s_cmd_ready),
        .busy           (busy),
        .err            (err),
        .m_axi4_arid    (arid),
        .m_axi4_araddr  (araddr),
        .m_axi4_arlen   (arlen),
        .m_axi4_arsize  (arsize),
        .m_axi4_arburst (arburst),
        .m_axi4_arlock  (arlock),
        .m_axi4_arcache (arcache),
        .m_axi4_arprot  (arprot),
        .m_axi4_arqos   (arqos),
        .m_axi4_arvalid (arvalid),
        .m_axi4_arready (arready),
        .m_axi4_rid     (rid),
        .m_axi4_rdata   (rdata),
        .m_axi4_rresp   (rresp),
        .m_axi4_rlast   (rlast),
        .m_axi4_rvalid  (rvalid),
        .m_axi4_rready  (rready),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready)
    );

    int     checks = 0;
    int     errors = 0;
    beat_t  sb[$];
    ar_t    ar_exp[$];
    burst_t bq[$];
    int     ar_seen = 0;
    int     outst = 0;
    int     r_beats = 0;
    int     err_abs = -1;
    bit     r_taken = 0;
    bit     rand_mode = 0;
    bit     hold_mready = 0;
    vec_t   vecs[7];

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(logic [48:0] a);
        return {32'hC0DE_5EED, 47'h0, a};
    endfunction

    // Memory slave: AR accepts come from the monitor;
    // beats are returned in order, one burst at a time.
    initial begin : slave
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 2'd0;
        rdata   = '0;
        rid     = '0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bq.delete();
                rvalid  = 1'b0;
                rlast   = 1'b0;
                rresp   = 2'd0;
                r_taken = 0;
                arready = 1'b0;
                m_ready = 1'b0;
            end else begin
                arready = rand_mode ?
                    1'($urandom_range(0, 1)) : 1'b1;
                m_ready = hold_mready ? 1'b0 :
                    rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (r_taken && bq.size() > 0) begin
                    burst_t b;
                    b = bq.pop_front();
                    b.left--;
                    b.a += 49'd16;
                    if (b.left > 0) bq.push_front(b);
                    r_beats++;
                    rvalid = 1'b0;
                end
                r_taken = 0;
                if (!rvalid && bq.size() > 0 &&
                    (!rand_mode || $urandom_range(0, 3) != 0)) begin
                    rvalid = 1'b1;
                    rdata  = pat(bq[0].a);
                    rlast  = (bq[0].left == 1);
                    rresp  = (r_beats == err_abs) ? 2'd2 : 2'd0;
                end
            end
        end
    end

    initial begin : mon
        bit         ar_pend = 0;
        bit         chk_done = 0;
        logic [48:0] hold_a = '0;
        logic [7:0]  hold_l = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                outst    = 0;
                ar_pend  = 0;
                chk_done = 0;
            end else begin
                if (chk_done) begin
                    chk("done_busy", 128'(busy), 128'(0));
                    chk("done_ready", 128'(s_cmd_ready), 128'(1));
                    chk_done = 0;
                end
                if (ar_pend) begin
                    chk("ar_hold_valid", 128'(arvalid), 128'(1));
                    chk("ar_hold_addr", 128'(araddr), 128'(hold_a));
                    chk("ar_hold_len", 128'(arlen), 128'(hold_l));
                end
                ar_pend = arvalid && !arready;
                hold_a  = araddr;
                hold_l  = arlen;
                if (arvalid && arready) begin
                    ar_seen++;
                    outst++;
                    chk("ar_limit", 128'(outst <= 4), 128'(1));
                    chk("ar_fields",
                        128'({arsize, arburst, arcache, arlock,
                              arprot, arqos, arid}),
                        128'({3'd4, 2'd1, 4'd3, 1'b0,
                              3'd0, 4'd0, 6'd0}));
                    chk("ar_expected", 128'(ar_exp.size() != 0),
                        128'(1));
                    if (ar_exp.size() != 0) begin
                        ar_t e;
                        e = ar_exp.pop_front();
                        chk("araddr", 128'(araddr), 128'(e.a));
                        chk("arlen", 128'(arlen), 128'(e.len));
                    end
                    bq.push_back('{araddr, int'(arlen) + 1});
                end
                if (m_valid && m_ready) begin
                    chk("beat_expected", 128'(sb.size() != 0),
                        128'(1));
                    if (sb.size() != 0) begin
                        beat_t e;
                        e = sb.pop_front();
                        chk("m_data", m_data, e.d);
                        chk("m_last", 128'(m_last), 128'(e.l));
                    end
                    if (rlast) outst--;
                    if (m_last) chk_done = 1;
                    r_taken = 1;
                end
            end
        end
    end

    // Reference split: min(remaining, 16, beats to 4 KB).
    task automatic push_model(input logic [48:0] a,
                              input int len);
        logic [48:0] x;
        int rem, bnd, n;
        x = a & ~49'hF;
        for (int i = 0; i < len; i++) begin
            sb.push_back('{pat(x + 49'(i * 16)), i == len - 1});
        end
        rem = len;
        while (rem > 0) begin
            bnd = (4096 - int'(x[11:0])) / 16;
            n = rem;
            if (n > 16) n = 16;
            if (n > bnd) n = bnd;
            ar_exp.push_back('{x, 8'(n - 1)});
            x += 49'(n * 16);
            rem -= n;
        end
    endtask

    task automatic issue_cmd(input logic [48:0] a,
                             input int len, input int eb);
        int k;
        k = 0;
        while (!s_cmd_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("cmd_ready", 128'(s_cmd_ready), 128'(1));
        push_model(a, len);
        ar_seen = 0;
        err_abs = (eb < 0) ? -1 : r_beats + eb;
        s_cmd_addr  = a;
        s_cmd_len   = 32'(len);
        s_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        s_cmd_valid = 1'b0;
        chk("busy_on_accept", 128'(busy), 128'(1));
        chk("arvalid_t1", 128'(arvalid), 128'(len != 0));
        chk("err_cleared", 128'(err), 128'(0));
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("busy_done", 128'(busy), 128'(0));
        chk("sb_drained", 128'(sb.size()), 128'(0));
        chk("ar_drained", 128'(ar_exp.size()), 128'(0));
        chk("ready_done", 128'(s_cmd_ready), 128'(1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
        chk({tag, "_arvalid"}, 128'(arvalid), 128'(0));
        chk({tag, "_araddr"}, 128'(araddr), 128'(0));
        chk({tag, "_arlen"}, 128'(arlen), 128'(0));
        chk({tag, "_m_last"}, 128'(m_last), 128'(0));
        chk({tag, "_ready"}, 128'(s_cmd_ready), 128'(0));
    endtask

    initial begin : main
        int cyc;
        vecs[0] = '{49'h1000, 4, -1, 1'b0, 1, 1'b0};
        vecs[1] = '{49'h0, 40, -1, 1'b0, 3, 1'b0};
        vecs[2] = '{49'hFC0, 8, -1, 1'b0, 2, 1'b0};
        vecs[3] = '{49'h0, 8, 2, 1'b0, 1, 1'b1};
        vecs[4] = '{49'h123_4567_89AB, 37, -1, 1'b1, 3, 1'b0};
        vecs[5] = '{49'h1_FFFF_FFFF_FFC0, 8, -1, 1'b1, 2, 1'b0};
        vecs[6] = '{49'h3F00, 100, 50, 1'b1, 7, 1'b1};

        reset       = 1'b1;
        s_cmd_addr  = '0;
        s_cmd_len   = '0;
        s_cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 128'(s_cmd_ready), 128'(1));

        for (int i = 0; i < 7; i++) begin
            rand_mode = vecs[i].rnd;
            issue_cmd(vecs[i].addr, vecs[i].len, vecs[i].eb);
            wait_done(cyc);
            chk("ar_count", 128'(ar_seen), 128'(vecs[i].n_ar));
            chk("err_end", 128'(err), 128'(vecs[i].e_err));
        end

        rand_mode = 0;
        issue_cmd(49'h500, 0, -1);
        wait_done(cyc);
        chk("len0_busy_cycles", 128'(cyc), 128'(1));
        chk("len0_ar_count", 128'(ar_seen), 128'(0));

        hold_mready = 1;
        issue_cmd(49'h0, 256, -1);
        repeat (40) @(posedge clk);
        #1;
        chk("stall_ar_count", 128'(ar_seen), 128'(4));
        chk("stall_arvalid", 128'(arvalid), 128'(0));
        hold_mready = 0;
        wait_done(cyc);
        chk("stall_ar_total", 128'(ar_seen), 128'(16));

        issue_cmd(49'h2000, 64, -1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        ar_exp.delete();
        @(posedge clk);
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_midrst", 128'(s_cmd_ready), 128'(1));
        issue_cmd(49'h3000, 4, -1);
        wait_done(cyc);
        chk("post_rst_ar_count", 128'(ar_seen), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
